// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR width, tap mask, default seed, FSM encoding and helpers
package lfsr_pkg;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'h65;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01;
  typedef enum logic {S_RUN, S_INJECT} state_t;
  function automatic logic [LFSR_W-1:0] guard_seed(input logic [LFSR_W-1:0] s, input logic [LFSR_W-1:0] d);
    return (s == '0) ? d : s;
  endfunction
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/lfsr_generator_step.sv
// lfsr_step: combinational Galois next-state function built from TAP_MASK
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] i_q,
  output logic [LFSR_W-1:0] o_n
);
  assign o_n = {i_q[LFSR_W-2:0], 1'b0} ^ (i_q[LFSR_W-1] ? TAP_MASK : '0);
endmodule

// File: rtl/lfsr_generator.sv
// lfsr_generator: 8-bit Galois LFSR source with seed reload, period measurement and error injection (LFSR_GEN_INJECT_EN)
module lfsr_generator
  import lfsr_pkg::*;
#(
  parameter logic [7:0] SEED        = DEFAULT_SEED,
  parameter int         INJECT_LEN  = 4,
  parameter logic [7:0] INJECT_MASK = 8'h01
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic       i_soft_reset,
  input  logic [7:0] i_seed,
  input  logic       i_inject,
  output logic [7:0] o_LFSR,
  output logic       o_valid,
  output logic       o_inject_busy,
  output logic       o_wrap,
  output logic [7:0] o_period
);
  logic [7:0] r_lfsr, r_seed, r_per_cnt, r_period;
  logic [7:0] w_step, w_seed_g;
  logic       r_valid, r_wrap, w_hit;
  lfsr_step u_step (.i_q(r_lfsr), .o_n(w_step));
  assign w_seed_g = guard_seed(i_seed, SEED);
  assign w_hit    = i_valid && (w_step == r_seed);
  // LFSR state, loaded seed, period counter and output flags
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_lfsr    <= SEED;
      r_seed    <= SEED;
      r_per_cnt <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (i_soft_reset) begin
      r_lfsr    <= w_seed_g;
      r_seed    <= w_seed_g;
      r_per_cnt <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_wrap  <= w_hit;
      if (i_valid) begin
        r_lfsr    <= w_step;
        r_per_cnt <= w_hit ? 8'h00 : sat_inc(r_per_cnt);
        if (w_hit) r_period <= sat_inc(r_per_cnt);
      end
    end
  end
  assign o_valid  = r_valid;
  assign o_wrap   = r_wrap;
  assign o_period = r_period;
`ifdef LFSR_GEN_INJECT_EN
  state_t     r_state, w_state_nxt;
  logic [3:0] r_inj_cnt, w_inj_cnt_nxt;
  // injection FSM state register
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state   <= S_RUN;
      r_inj_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_inj_cnt <= w_inj_cnt_nxt;
    end
  end
  // burst start on a valid request, countdown on valid edges, abort on soft reset
  always_comb begin
    w_state_nxt   = r_state;
    w_inj_cnt_nxt = r_inj_cnt;
    if (i_soft_reset) begin
      w_state_nxt   = S_RUN;
      w_inj_cnt_nxt = '0;
    end else if (i_valid && r_state == S_RUN && i_inject) begin
      w_state_nxt   = S_INJECT;
      w_inj_cnt_nxt = 4'(INJECT_LEN);
    end else if (i_valid && r_state == S_INJECT) begin
      w_inj_cnt_nxt = r_inj_cnt - 4'd1;
      w_state_nxt   = (r_inj_cnt == 4'd1) ? S_RUN : S_INJECT;
    end
  end
  assign o_inject_busy = (r_state == S_INJECT);
  assign o_LFSR        = r_lfsr ^ ((r_state == S_INJECT) ? INJECT_MASK : 8'h00);
`else
  logic w_unused;
  assign w_unused      = ^{i_inject, INJECT_MASK, 4'(INJECT_LEN)};
  assign o_inject_busy = 1'b0;
  assign o_LFSR        = r_lfsr;
`endif
endmodule

// File: tb/tb_lfsr_generator.sv
// tb_lfsr_generator: directed table-driven and sequence checks for lfsr_generator
module tb_lfsr_generator;
  logic       clk = 1'b0;
  logic       i_reset = 1'b1, i_valid = 1'b0, i_soft_reset = 1'b0, i_inject = 1'b0;
  logic [7:0] i_seed = 8'h00;
  logic [7:0] o_LFSR, o_period;
  logic       o_valid, o_inject_busy, o_wrap;
  int n_checks = 0;
  int n_errors = 0;
`ifdef LFSR_GEN_INJECT_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif
  always #5 clk = ~clk;
  lfsr_generator dut (
    .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_soft_reset(i_soft_reset),
    .i_seed(i_seed), .i_inject(i_inject), .o_LFSR(o_LFSR), .o_valid(o_valid),
    .o_inject_busy(o_inject_busy), .o_wrap(o_wrap), .o_period(o_period)
  );
  typedef struct {
    logic       v;
    logic       sr;
    logic [7:0] seed;
    logic       inj;
    logic [7:0] e_lfsr;
    logic       e_valid;
    logic       e_busy;
    logic       e_wrap;
  } vec_t;
  vec_t tbl[15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic v, input logic sr, input logic [7:0] s, input logic inj);
    i_reset = r;
    i_valid = v;
    i_soft_reset = sr;
    i_seed = s;
    i_inject = inj;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] gold(input logic [7:0] q);
    logic fb;
    fb = q[7];
    return {q[6], q[5] ^ fb, q[4] ^ fb, q[3], q[2], q[1] ^ fb, q[0], fb};
  endfunction
  initial begin
    logic [7:0] q;
    logic       v, bad;
    int         wraps, wrap_at, dups, steps;
    bit         seen[256];
    tbl = '{
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h65, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'hCA, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'hF1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'hF1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h65, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'hCA, 1'b1, 1'b0, 1'b0}
    };
    drive(1, 0, 0, 8'h00, 0);
    drive(1, 1, 0, 8'h00, 1);
    chk("reset_lfsr", o_LFSR, 8'h01);
    chk("reset_valid", o_valid, 0);
    chk("reset_busy", o_inject_busy, 0);
    chk("reset_wrap", o_wrap, 0);
    chk("reset_period", o_period, 0);
    for (int i = 0; i < 15; i++) begin
      drive(0, tbl[i].v, tbl[i].sr, tbl[i].seed, tbl[i].inj);
      chk($sformatf("tbl%0d_lfsr", i), o_LFSR, tbl[i].e_lfsr);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_busy", i), o_inject_busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_wrap", i), o_wrap, tbl[i].e_wrap);
    end
    drive(1, 0, 0, 8'h00, 0);
    q = 8'h01;
    wraps = 0;
    wrap_at = 0;
    dups = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      drive(0, 1, 0, 8'h00, 0);
      q = gold(q);
      chk($sformatf("wrap_step%0d", k), o_LFSR, q);
      if (o_wrap) begin
        wraps++;
        wrap_at = k;
      end
      if (k < 255 && seen[o_LFSR]) dups++;
      seen[o_LFSR] = 1'b1;
    end
    chk("wrap_count", wraps, 1);
    chk("wrap_at", wrap_at, 255);
    chk("wrap_period", o_period, 8'hFF);
    chk("wrap_no_repeat", dups, 0);
    drive(0, 1, 0, 8'h00, 0);
    chk("wrap_pulse_end", o_wrap, 0);
    chk("wrap_continue", o_LFSR, 8'h02);
    drive(1, 0, 0, 8'h00, 0);
    q = 8'h01;
    wraps = 0;
    wrap_at = 0;
    steps = 0;
    for (int c = 0; c < 510; c++) begin
      v = (c % 2 == 0);
      drive(0, v, 0, 8'h00, 0);
      if (v) begin
        q = gold(q);
        steps++;
      end
      chk($sformatf("alt%0d_lfsr", c), o_LFSR, q);
      chk($sformatf("alt%0d_valid", c), o_valid, v);
      if (o_wrap) begin
        wraps++;
        wrap_at = steps;
      end
    end
    chk("alt_wrap_count", wraps, 1);
    chk("alt_wrap_at", wrap_at, 255);
    chk("alt_period", o_period, 8'hFF);
    drive(1, 0, 0, 8'h00, 0);
    q = 8'h01;
    for (int k = 1; k <= 9; k++) begin
      drive(0, 1, 0, 8'h00, (k == 4 || k == 5));
      q = gold(q);
      bad = INJ_EN && k >= 4 && k <= 7;
      chk($sformatf("inj_step%0d_lfsr", k), o_LFSR, q ^ 8'(bad));
      chk($sformatf("inj_step%0d_busy", k), o_inject_busy, bad);
    end
    drive(1, 0, 0, 8'h00, 0);
    for (int k = 1; k <= 3; k++) drive(0, 1, 0, 8'h00, 0);
    drive(0, 1, 0, 8'h00, 1);
    drive(0, 1, 0, 8'h00, 0);
    chk("abort_pre_busy", o_inject_busy, INJ_EN);
    chk("abort_pre_lfsr", o_LFSR, 8'h20 ^ 8'(INJ_EN));
    drive(0, 1, 1, 8'h10, 1);
    chk("soft_abort_lfsr", o_LFSR, 8'h10);
    chk("soft_abort_busy", o_inject_busy, 0);
    chk("soft_abort_valid", o_valid, 0);
    drive(0, 1, 0, 8'h00, 0);
    chk("soft_restart_lfsr", o_LFSR, 8'h20);
    chk("soft_restart_busy", o_inject_busy, 0);
    drive(0, 1, 0, 8'h00, 1);
    chk("reinj_lfsr", o_LFSR, 8'h40 ^ 8'(INJ_EN));
    chk("reinj_busy", o_inject_busy, INJ_EN);
    drive(1, 1, 1, 8'h33, 1);
    chk("hard_abort_lfsr", o_LFSR, 8'h01);
    chk("hard_abort_busy", o_inject_busy, 0);
    chk("hard_abort_valid", o_valid, 0);
    drive(0, 1, 0, 8'h00, 0);
    chk("hard_restart_lfsr", o_LFSR, 8'h02);
    chk("hard_restart_busy", o_inject_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
